image_loader: RTL and testbench
===============================

// Module: image_loader
// PURPOSE
//   Front-end stage of the CNN pipeline, directly upstream of conv2d_layer.
//   Accepts a raster-order 8x8 image, one 8-bit pixel per accepted handshake, from the ui_in byte port.
//   Stores the image in an internal frame buffer and pulses loading_done, which drives conv2d_layer.start_processing.
//   Serves zero-padded random-access pixel reads to the convolution window, then waits for release before the next frame.
// PARAMETERS
//   IMG_W  8  image width in pixels
//   IMG_H  8  image height in pixels
//   PIX_W  8  pixel width in bits
//   Derived: N_PIX = IMG_W*IMG_H; CNT_W = clog2(N_PIX)
// PORTS
//   clk           in   1      clock; all state changes on posedge
//   reset         in   1      synchronous, active-high
//   in_data       in   PIX_W  pixel byte
//   in_valid      in   1      in_data valid this cycle
//   in_sof        in   1      marks first pixel of a frame; sampled only with in_valid
//   in_ready      out  1      loader accepts a byte this cycle; accept = in_valid & in_ready
//   rd_x          in   5      signed column, -16..15
//   rd_y          in   5      signed row, -16..15
//   rd_pixel      out  PIX_W  combinational pixel at (rd_x,rd_y)
//   loading_done  out  1      one-cycle pulse when a frame is complete
//   image_ready   out  1      level, high while a complete frame is held
//   release       in   1      consumer finished with frame; return to IDLE
//   load_error    out  1      checksum mismatch, sticky until next SOF (feature only)
// BEHAVIOUR
//   Reset values: in_ready=0, loading_done=0, image_ready=0, load_error=0, pix_cnt=0, state=IDLE.
//   Reset does not clear the frame buffer.
//   FSM states: IDLE, LOAD, CHK (feature only), READY.
//   in_ready = 1 in IDLE, LOAD and CHK; 0 in READY and in the cycle reset is high.
//   IDLE:
//     - accept with in_sof=1: buf[0]<=in_data, pix_cnt<=1, go to LOAD.
//     - accept with in_sof=0: byte dropped, stay in IDLE.
//   LOAD:
//     - accept with in_sof=1: resync; buf[0]<=in_data, pix_cnt<=1.
//     - accept with in_sof=0: buf[pix_cnt]<=in_data, pix_cnt<=pix_cnt+1.
//     - accept writing index N_PIX-1: go to READY (or CHK with the feature); pix_cnt<=0.
//     - no accept: hold all state; gaps of any length are allowed.
//   Raster order: index = y*IMG_W + x.
//   loading_done: registered, high for exactly one cycle, the cycle image_ready first goes high.
//     - Latency: loading_done is high the cycle after the final pixel (or checksum byte) is accepted.
//   READY:
//     - image_ready=1; every in_valid is ignored (in_ready=0).
//     - release=1: go to IDLE next cycle, image_ready<=0.
//     - release in any other state is ignored.
//   rd_pixel:
//     - returns 0 if rd_x<0, rd_x>=IMG_W, rd_y<0 or rd_y>=IMG_H (zero padding).
//     - returns 0 when image_ready=0.
//     - otherwise returns buf[rd_y*IMG_W+rd_x].
//     - purely combinational, no latency.
//   Reset mid-load: the partial frame is discarded; the next frame must start with in_sof.
//   Simultaneous release and in_valid in READY: release wins; the byte is not accepted (in_ready=0).
// CONFIGURATION
//   IMAGE_LOADER_CHKSUM_EN defined:
//     - an XOR checksum accumulates over all N_PIX pixels, restarting at SOF.
//     - after the last pixel, FSM enters CHK and accepts one more byte (in_sof ignored).
//     - load_error<=(byte!=xor), then go to READY; loading_done pulses regardless of the result.
//     - load_error clears on the next accepted SOF.
//   IMAGE_LOADER_CHKSUM_EN undefined:
//     - no CHK state; last pixel goes straight to READY.
//     - load_error is tied to 0.
// TESTING
//   1. Stream 0..63 back-to-back, SOF on 0 -> loading_done one cycle after byte 63; rd(3,2)=19; rd(-1,0)=0; rd(8,7)=0.
//   2. Same frame, in_valid every 3rd cycle -> identical buffer; loading_done exactly once; in_ready=1 throughout load.
//   3. 20 bytes, then SOF frame of all 8'hA5 -> rd(0,0)=A5, rd(4,2)=A5 (stale data overwritten); one loading_done.
//   4. In READY, drive in_valid with 8'hFF, then release -> buffer unchanged; image_ready=0 next cycle; rd_pixel=0; next SOF accepted.
//   5. Reset at pixel 30, then full frame of 8'h11 -> no loading_done before the new frame; all reads 11.
//   6. CHKSUM_EN: frame 0..63 (xor=0) + byte 0x00 -> load_error=0; repeat with 0x01 -> load_error=1, loading_done still pulses.

Source files
------------

// File: rtl/image_loader.sv
// image_loader
//   Front end of the CNN pipeline. Captures one raster-order IMG_W x IMG_H
//   frame of PIX_W-bit pixels from a valid/ready byte stream into a frame
//   buffer, pulses loading_done_o when the frame is complete, then serves
//   zero-padded random-access reads to the convolution window until the
//   consumer releases the frame.
//
//   Optional feature macro: IMAGE_LOADER_CHKSUM_EN
//     When defined, an XOR checksum byte follows the last pixel. Its result
//     is reported on load_error_o. The frame is still marked ready either way.
//     When undefined, load_error_o is tied to 0.
//
// Ports
//   clk             clock, all state changes on posedge
//   reset           synchronous, active-high
//   in_data_i       pixel byte
//   in_valid_i      in_data_i valid this cycle
//   in_sof_i        first pixel of a frame (sampled only with in_valid_i)
//   in_ready_o      byte accepted this cycle when in_valid_i is also high
//   rd_x_i, rd_y_i  signed 5-bit read coordinates (-16..15)
//   rd_pixel_o      combinational pixel at (rd_x_i, rd_y_i), 0 outside the image
//   loading_done_o  one-cycle pulse when the frame becomes ready
//   image_ready_o   high while a complete frame is held
//   release_i       consumer is done with the frame
//   load_error_o    checksum mismatch, sticky until the next accepted SOF
module image_loader #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] in_data_i,
  input  logic             in_valid_i,
  input  logic             in_sof_i,
  output logic             in_ready_o,
  input  logic [4:0]       rd_x_i,
  input  logic [4:0]       rd_y_i,
  output logic [PIX_W-1:0] rd_pixel_o,
  output logic             loading_done_o,
  output logic             image_ready_o,
  input  logic             release_i,
  output logic             load_error_o
);

  localparam int N_PIX = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(N_PIX);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef IMAGE_LOADER_CHKSUM_EN
    CHK   = 2'd2,
`endif
    READY = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] pix_cnt_q;
  logic             loading_done_q;
  logic             image_ready_q;
  logic [PIX_W-1:0] fb_q [N_PIX];

  logic             accept;
  logic             wr_en;
  logic [CNT_W-1:0] wr_idx;

  // Ready is a pure function of state so the source sees back-pressure the
  // same cycle the frame is captured; it is forced low while reset is held.
  assign in_ready_o = !reset && (state_q != READY);
  assign accept     = in_valid_i && in_ready_o;

  // A SOF byte always lands at index 0 (start or resync); a non-SOF byte is
  // only stored while a frame is in progress, so stray bytes in IDLE drop.
  assign wr_en  = accept && (in_sof_i ? (state_q == IDLE || state_q == LOAD)
                                      : (state_q == LOAD));
  assign wr_idx = in_sof_i ? '0 : pix_cnt_q;

  // Frame buffer has no reset: stale contents are harmless because reads are
  // gated by image_ready.
  always_ff @(posedge clk) begin
    if (wr_en) fb_q[wr_idx] <= in_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pix_cnt_q      <= '0;
      loading_done_q <= 1'b0;
      image_ready_q  <= 1'b0;
    end else begin
      loading_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && in_sof_i) begin
            pix_cnt_q <= CNT_W'(1);
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            if (in_sof_i) begin
              pix_cnt_q <= CNT_W'(1);
            end else if (pix_cnt_q == LAST_IDX) begin
              pix_cnt_q <= '0;
`ifdef IMAGE_LOADER_CHKSUM_EN
              state_q   <= CHK;
`else
              state_q        <= READY;
              loading_done_q <= 1'b1;
              image_ready_q  <= 1'b1;
`endif
            end else begin
              pix_cnt_q <= pix_cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef IMAGE_LOADER_CHKSUM_EN
        CHK: begin
          if (accept) begin
            state_q        <= READY;
            loading_done_q <= 1'b1;
            image_ready_q  <= 1'b1;
          end
        end
`endif
        READY: begin
          if (release_i) begin
            state_q       <= IDLE;
            image_ready_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IMAGE_LOADER_CHKSUM_EN
  logic [PIX_W-1:0] xor_q;
  logic             load_error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      xor_q        <= '0;
      load_error_q <= 1'b0;
    end else if (wr_en && in_sof_i) begin
      xor_q        <= in_data_i;
      load_error_q <= 1'b0;
    end else if (wr_en) begin
      xor_q <= xor_q ^ in_data_i;
    end else if (accept && state_q == CHK) begin
      load_error_q <= (in_data_i != xor_q);
    end
  end

  assign load_error_o = load_error_q;
`else
  assign load_error_o = 1'b0;
`endif

  // Zero-padded read port: coordinates are sign-extended so negative values
  // fall outside the image and return 0.
  int               x_int;
  int               y_int;
  logic             in_range;
  logic [CNT_W-1:0] rd_idx;

  always_comb begin
    x_int      = int'(signed'(rd_x_i));
    y_int      = int'(signed'(rd_y_i));
    in_range   = (x_int >= 0) && (x_int < IMG_W) && (y_int >= 0) && (y_int < IMG_H);
    rd_idx     = CNT_W'(y_int * IMG_W + x_int);
    rd_pixel_o = '0;
    if (image_ready_q && in_range) rd_pixel_o = fb_q[rd_idx];
  end

  assign loading_done_o = loading_done_q;
  assign image_ready_o  = image_ready_q;

endmodule

// File: tb/tb_image_loader.sv
module tb_image_loader;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NP = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic       in_sof_i;
  logic       in_ready_o;
  logic [4:0] rd_x_i;
  logic [4:0] rd_y_i;
  logic [7:0] rd_pixel_o;
  logic       loading_done_o;
  logic       image_ready_o;
  logic       release_i;
  logic       load_error_o;

  image_loader #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_sof_i(in_sof_i),
    .in_ready_o(in_ready_o),
    .rd_x_i(rd_x_i), .rd_y_i(rd_y_i), .rd_pixel_o(rd_pixel_o),
    .loading_done_o(loading_done_o), .image_ready_o(image_ready_o),
    .release_i(release_i), .load_error_o(load_error_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;

  int         done_q[$];   // expected cycles of loading_done pulses
  logic [7:0] exp_q[$];    // expected read data
  logic [7:0] mem [NP];    // bench copy of the frame
  bit         model_ready = 1'b0;
`ifdef IMAGE_LOADER_CHKSUM_EN
  logic [7:0] chk_flip = 8'h00;
`endif

  typedef struct {
    int         x;
    int         y;
    logic [7:0] exp;
  } rd_vec_t;
  rd_vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // loading_done monitor: every pulse must match a pushed expectation.
  always @(negedge clk) begin
    if (!reset && loading_done_o) begin
      if (done_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL loading_done_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        int e;
        e = done_q.pop_front();
        chk("loading_done_cycle", cyc, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_px(input int x, input int y);
    if (model_ready && x >= 0 && x < W && y >= 0 && y < H) return mem[y*W + x];
    return 8'h00;
  endfunction

  task automatic rd(input int x, input int y, input string name, input logic [7:0] e);
    logic [7:0] got_exp;
    rd_x_i = 5'(x);
    rd_y_i = 5'(y);
    exp_q.push_back(e);
    #2;
    got_exp = exp_q.pop_front();
    chk(name, rd_pixel_o, got_exp);
  endtask

  task automatic sweep(input string name);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        rd(x, y, name, model_px(x, y));
  endtask

  task automatic send(input logic [7:0] d, input logic sof, input int gap,
                      input bit exp_rdy, input bit last);
    for (int g = 0; g < gap; g++) begin
      in_valid_i = 1'b0;
      if (exp_rdy) chk("in_ready_gap", in_ready_o, 1);
      tick();
    end
    in_data_i  = d;
    in_sof_i   = sof;
    in_valid_i = 1'b1;
    chk("in_ready", in_ready_o, exp_rdy);
    if (last) done_q.push_back(cyc + 1);
    tick();
    in_valid_i = 1'b0;
    in_sof_i   = 1'b0;
  endtask

  // mode 0: pixel = index, 1: constant cval, 2: index*3
  task automatic send_frame(input int mode, input logic [7:0] cval, input int gap);
    logic [7:0] d;
`ifdef IMAGE_LOADER_CHKSUM_EN
    logic [7:0] x = 8'h00;
`endif
    for (int i = 0; i < NP; i++) begin
      d = (mode == 0) ? 8'(i) : (mode == 1) ? cval : 8'(i * 3);
      mem[i] = d;
`ifdef IMAGE_LOADER_CHKSUM_EN
      x = x ^ d;
      send(d, i == 0, gap, 1'b1, 1'b0);
`else
      send(d, i == 0, gap, 1'b1, i == NP - 1);
`endif
    end
`ifdef IMAGE_LOADER_CHKSUM_EN
    send(x ^ chk_flip, 1'b0, gap, 1'b1, 1'b1);
`endif
    model_ready = 1'b1;
    chk("image_ready_after_frame", image_ready_o, 1);
    chk("in_ready_in_ready_state", in_ready_o, 0);
    tick();
    chk("loading_done_single_cycle", loading_done_o, 0);
    chk("done_queue_drained", done_q.size(), 0);
  endtask

  task automatic do_release();
    release_i = 1'b1;
    tick();
    release_i   = 1'b0;
    model_ready = 1'b0;
    chk("image_ready_after_release", image_ready_o, 0);
    chk("in_ready_after_release", in_ready_o, 1);
  endtask

  initial begin
    vecs[0] = '{x: 3,   y: 2,   exp: 8'd19};
    vecs[1] = '{x: -1,  y: 0,   exp: 8'd0};
    vecs[2] = '{x: 8,   y: 7,   exp: 8'd0};
    vecs[3] = '{x: 0,   y: 0,   exp: 8'd0};
    vecs[4] = '{x: 7,   y: 7,   exp: 8'd63};
    vecs[5] = '{x: 0,   y: -1,  exp: 8'd0};
    vecs[6] = '{x: -16, y: -16, exp: 8'd0};
    vecs[7] = '{x: 15,  y: 3,   exp: 8'd0};
    vecs[8] = '{x: 0,   y: 8,   exp: 8'd0};
    vecs[9] = '{x: 7,   y: 0,   exp: 8'd7};

    reset = 1'b1; in_data_i = '0; in_valid_i = 1'b0; in_sof_i = 1'b0;
    rd_x_i = '0; rd_y_i = '0; release_i = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_loading_done", loading_done_o, 0);
    chk("rst_image_ready", image_ready_o, 0);
    chk("rst_load_error", load_error_o, 0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", in_ready_o, 1);
    rd(0, 0, "rd_not_ready", 8'h00);

    // 1: back-to-back frame 0..63
    send_frame(0, 8'h00, 0);
    for (int i = 0; i < 10; i++) rd(vecs[i].x, vecs[i].y, "rd_table", vecs[i].exp);
    chk("t1_load_error", load_error_o, 0);

    // 2: same frame, one valid every 3rd cycle
    do_release();
    send_frame(0, 8'h00, 2);
    sweep("t2_sweep");

    // 3: 20 bytes of a partial frame, then a fresh SOF frame of A5
    do_release();
    for (int i = 0; i < 20; i++) send(8'(8'h30 + i), i == 0, 0, 1'b1, 1'b0);
    send_frame(1, 8'hA5, 0);
    rd(0, 0, "t3_rd00", 8'hA5);
    rd(4, 2, "t3_rd42", 8'hA5);
    sweep("t3_sweep");

    // 4: bytes offered in READY are ignored; release wins over in_valid
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1; in_data_i = 8'hFF; in_sof_i = (i == 0);
      chk("t4_in_ready_blocked", in_ready_o, 0);
      tick();
    end
    in_valid_i = 1'b0; in_sof_i = 1'b0;
    sweep("t4_unchanged");
    in_valid_i = 1'b1; in_data_i = 8'hFF; in_sof_i = 1'b1; release_i = 1'b1;
    chk("t4_in_ready_at_release", in_ready_o, 0);
    tick();
    in_valid_i = 1'b0; in_sof_i = 1'b0; release_i = 1'b0; model_ready = 1'b0;
    chk("t4_image_ready_low", image_ready_o, 0);
    chk("t4_in_ready_idle", in_ready_o, 1);
    rd(3, 3, "t4_rd_after_release", 8'h00);
    send_frame(2, 8'h00, 1);
    sweep("t4_next_frame");

    // 5: reset in the middle of a frame
    do_release();
    for (int i = 0; i < 30; i++) send(8'(8'h40 + i), i == 0, 0, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    chk("t5_in_ready_in_reset", in_ready_o, 0);
    reset = 1'b0;
    #1;
    chk("t5_image_ready", image_ready_o, 0);
    send(8'h77, 1'b0, 0, 1'b1, 1'b0);   // no SOF: dropped in IDLE
    rd(0, 0, "t5_rd_idle", 8'h00);
    send_frame(1, 8'h11, 0);
    sweep("t5_sweep");

`ifdef IMAGE_LOADER_CHKSUM_EN
    // 6: checksum good, then bad, then cleared by the next SOF
    do_release();
    chk_flip = 8'h00;
    send_frame(0, 8'h00, 0);
    chk("t6_load_error_good", load_error_o, 0);
    do_release();
    chk_flip = 8'h01;
    send_frame(0, 8'h00, 0);
    chk("t6_load_error_bad", load_error_o, 1);
    sweep("t6_sweep");
    do_release();
    chk("t6_error_sticky", load_error_o, 1);
    send(8'h00, 1'b1, 0, 1'b1, 1'b0);
    chk("t6_error_cleared", load_error_o, 0);
`else
    chk("load_error_tied", load_error_o, 0);
`endif

    tick(); tick();
    chk("loading_done_missing", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
